// File: rtl/button_led_sequencer_pkg.sv
`default_nettype none
// ============================================================================
// Module      : button_led_sequencer_pkg
// Description : Shared FSM state encoding and default parameter values for
//               the button/LED sequencer and its per-channel debouncer.
// Ports       : none (package)
// Revision    : 1.0 - initial release
// ============================================================================
package button_led_sequencer_pkg;

  // Sequencer modes: free-running rotation, button hold, paused.
  typedef enum logic [1:0] {
    ST_RUN   = 2'd0,
    ST_HOLD  = 2'd1,
    ST_PAUSE = 2'd2
  } state_t;

  localparam int DEF_NUM_CH       = 8;
  localparam int DEF_STEP_CYC     = 16777216;
  localparam int DEF_DEBOUNCE_CYC = 1000000;

endpackage
`default_nettype wire

// File: rtl/button_debounce.sv
`default_nettype none
// ============================================================================
// Module      : button_debounce
// Description : One button channel: 2-flop synchronizer followed by a
//               consecutive-cycle debounce counter.
// Ports       : clk      - clock
//               rst      - asynchronous active-high reset
//               switch_n - raw asynchronous button, active-low
//               pressed  - debounced press level (1 = pressed)
// Revision    : 1.0 - initial release
// ============================================================================
module button_debounce
  import button_led_sequencer_pkg::*;
#(
  parameter int DEBOUNCE_CYC = DEF_DEBOUNCE_CYC
) (
  input  logic clk,
  input  logic rst,
  input  logic switch_n,
  output logic pressed
);

  localparam int               CNT_W    = $clog2(DEBOUNCE_CYC + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYC - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  logic             sync1;
  logic             sync2;
  logic             sync_pressed;
  logic [CNT_W-1:0] cnt;

  assign sync_pressed = ~sync2;

  // Synchronizer resets to 1 so a reset looks like "button released".
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1 <= 1'b1;
      sync2 <= 1'b1;
    end else begin
      sync1 <= switch_n;
      sync2 <= sync1;
    end
  end

  // The output flips only after DEBOUNCE_CYC consecutive disagreeing cycles;
  // a single agreeing cycle restarts the count.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt     <= '0;
      pressed <= 1'b0;
    end else if (sync_pressed != pressed) begin
      if (cnt == CNT_LAST) begin
        pressed <= sync_pressed;
        cnt     <= '0;
      end else begin
        cnt <= cnt + CNT_ONE;
      end
    end else begin
      cnt <= '0;
    end
  end

endmodule
`default_nettype wire

// File: rtl/button_led_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : button_led_sequencer
// Description : Rotates a one-hot LED pattern every STEP_CYC cycles. A
//               debounced button press overrides the rotation and shows the
//               lowest-indexed pressed channel until all buttons are released.
// Ports       : Clk     - clock
//               Reset   - asynchronous active-high reset
//               Switch  - raw buttons, active-low, NUM_CH bits
//               Run     - 1 = rotate, 0 = pause
//               Dir     - 0 = rotate toward LSB, 1 = toward MSB
//               LED     - one-hot LED pattern
//               Pressed - debounced press levels
//               Step    - one-cycle pulse on each rotation
// Revision    : 1.0 - initial release
// ============================================================================
module button_led_sequencer
  import button_led_sequencer_pkg::*;
#(
  parameter int NUM_CH       = DEF_NUM_CH,
  parameter int STEP_CYC     = DEF_STEP_CYC,
  parameter int DEBOUNCE_CYC = DEF_DEBOUNCE_CYC
) (
  input  logic              Clk,
  input  logic              Reset,
  input  logic [NUM_CH-1:0] Switch,
  input  logic              Run,
  input  logic              Dir,
  output logic [NUM_CH-1:0] LED,
  output logic [NUM_CH-1:0] Pressed,
  output logic              Step
);

  localparam int                STEP_W    = $clog2(STEP_CYC);
  localparam logic [STEP_W-1:0] STEP_LAST = STEP_W'(STEP_CYC - 1);
  localparam logic [STEP_W-1:0] STEP_ONE  = STEP_W'(1);
  localparam logic [NUM_CH-1:0] LED_INIT  = NUM_CH'(1);

  state_t            state;
  state_t            state_next;
  logic [STEP_W-1:0] step_cnt;
  logic [STEP_W-1:0] step_cnt_next;
  logic [NUM_CH-1:0] led_next;
  logic [NUM_CH-1:0] led_rot;
  logic [NUM_CH-1:0] lowest_pressed;
  logic              step_next;
  logic              any_pressed;
  logic              terminal;

  generate
    for (genvar i = 0; i < NUM_CH; i++) begin : g_debounce
      button_debounce #(
        .DEBOUNCE_CYC(DEBOUNCE_CYC)
      ) u_debounce (
        .clk     (Clk),
        .rst     (Reset),
        .switch_n(Switch[i]),
        .pressed (Pressed[i])
      );
    end
  endgenerate

  assign any_pressed = |Pressed;
  assign terminal    = (step_cnt == STEP_LAST);

  // Rotating a one-hot vector can never produce anything but one-hot, so Dir
  // may change at any time without corrupting the pattern.
  assign led_rot = Dir ? {LED[NUM_CH-2:0], LED[NUM_CH-1]}
                       : {LED[0], LED[NUM_CH-1:1]};

  // Priority encoder: scanning from the top leaves the lowest set bit.
  always_comb begin
    lowest_pressed = '0;
    for (int i = NUM_CH - 1; i >= 0; i--) begin
      if (Pressed[i]) begin
        lowest_pressed    = '0;
        lowest_pressed[i] = 1'b1;
      end
    end
  end

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state    <= ST_RUN;
      step_cnt <= '0;
      LED      <= LED_INIT;
      Step     <= 1'b0;
    end else begin
      state    <= state_next;
      step_cnt <= step_cnt_next;
      LED      <= led_next;
      Step     <= step_next;
    end
  end

  // A press takes priority over everything, including a terminal count
  // landing in the same cycle.
  always_comb begin
    state_next    = state;
    step_cnt_next = step_cnt;
    led_next      = LED;
    step_next     = 1'b0;
    if (any_pressed) begin
      state_next    = ST_HOLD;
      step_cnt_next = '0;
      led_next      = lowest_pressed;
    end else begin
      case (state)
        ST_HOLD: begin
          state_next    = Run ? ST_RUN : ST_PAUSE;
          step_cnt_next = '0;
        end
        ST_PAUSE: begin
          if (Run) begin
            state_next = ST_RUN;
          end
        end
        ST_RUN: begin
          if (!Run) begin
            state_next = ST_PAUSE;
          end else if (terminal) begin
            step_cnt_next = '0;
            led_next      = led_rot;
            step_next     = 1'b1;
          end else begin
            step_cnt_next = step_cnt + STEP_ONE;
          end
        end
        default: begin
          state_next    = ST_RUN;
          step_cnt_next = '0;
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_button_led_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : tb_button_led_sequencer
// Description : Self-checking bench for button_led_sequencer (NUM_CH=8,
//               STEP_CYC=4, DEBOUNCE_CYC=3): directed scenarios followed by
//               random button/Run/Dir activity against a behavioural model.
// Ports       : none
// Revision    : 1.0 - initial release
// ============================================================================
module tb_button_led_sequencer;

  localparam int N = 8;
  localparam int S = 4;
  localparam int D = 3;

  logic         clk = 1'b0;
  logic         rst;
  logic [N-1:0] sw;
  logic         run;
  logic         dir;
  logic [N-1:0] led;
  logic [N-1:0] pressed;
  logic         step;

  int n_assert = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  button_led_sequencer #(
    .NUM_CH      (N),
    .STEP_CYC    (S),
    .DEBOUNCE_CYC(D)
  ) dut (
    .Clk    (clk),
    .Reset  (rst),
    .Switch (sw),
    .Run    (run),
    .Dir    (dir),
    .LED    (led),
    .Pressed(pressed),
    .Step   (step)
  );

  // Behavioural model: LED kept as a bit position, rotation as modular
  // arithmetic, debounce as a run length of disagreeing synchronized samples.
  logic [N-1:0] m_s1, m_s2, m_pr;
  int           m_len[N];
  int           m_pos;
  int           m_phase;
  bit           m_held, m_paused, m_step;

  function automatic int lowest_idx(input logic [N-1:0] v);
    for (int i = 0; i < N; i++) if (v[i]) return i;
    return 0;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_s1 = '1; m_s2 = '1; m_pr = '0;
    for (int i = 0; i < N; i++) m_len[i] = 0;
    m_pos = 0; m_phase = 0; m_held = 0; m_paused = 0; m_step = 0;
  endtask

  task automatic model_edge();
    logic [N-1:0] old_pr;
    old_pr = m_pr;
    for (int i = 0; i < N; i++) begin
      if ((~m_s2[i]) != m_pr[i]) begin
        m_len[i]++;
        if (m_len[i] == D) begin
          m_pr[i]  = ~m_pr[i];
          m_len[i] = 0;
        end
      end else begin
        m_len[i] = 0;
      end
    end
    m_s2 = m_s1;
    m_s1 = sw;
    m_step = 0;
    if (old_pr != '0) begin
      m_held  = 1;
      m_phase = 0;
      m_pos   = lowest_idx(old_pr);
    end else if (m_held) begin
      m_held   = 0;
      m_paused = !run;
    end else if (m_paused) begin
      m_paused = !run;
    end else if (!run) begin
      m_paused = 1;
    end else begin
      m_phase++;
      if (m_phase == S) begin
        m_phase = 0;
        m_pos   = dir ? (m_pos + 1) % N : (m_pos + N - 1) % N;
        m_step  = 1;
      end
    end
  endtask

  task automatic tick();
    @(posedge clk);
    model_edge();
    #1;
    chk("led", {24'd0, led}, 32'd1 << m_pos);
    chk("pressed", {24'd0, pressed}, {24'd0, m_pr});
    chk("step", {31'd0, step}, {31'd0, m_step});
  endtask

  task automatic ticks(input int n);
    for (int k = 0; k < n; k++) tick();
  endtask

  // Asserted between edges; the outputs must clear without waiting for Clk.
  task automatic do_reset();
    rst = 1'b1;
    #1;
    model_reset();
    chk("rst_led", {24'd0, led}, 32'h01);
    chk("rst_pressed", {24'd0, pressed}, 32'h00);
    chk("rst_step", {31'd0, step}, 32'd0);
    @(posedge clk);
    @(posedge clk);
    #1;
    chk("rst_hold_led", {24'd0, led}, 32'h01);
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    bit found;
    int b;
    rst = 1'b1; sw = '1; run = 1'b1; dir = 1'b0;
    #2;
    do_reset();

    // Free rotation toward LSB: 01 -> 80 -> 40.
    for (int k = 1; k <= 8; k++) begin
      tick();
      if (k == 3) chk("r030_nostep", {31'd0, step}, 32'd0);
      if (k == 4) begin
        chk("r030_led80", {24'd0, led}, 32'h80);
        chk("r030_step", {31'd0, step}, 32'd1);
      end
      if (k == 8) chk("r030_led40", {24'd0, led}, 32'h40);
    end

    // Press and hold channel 5, then release.
    sw[5] = 1'b0;
    for (int k = 1; k <= 12; k++) begin
      tick();
      if (k == 4) chk("r031_pr_early", {24'd0, pressed}, 32'h00);
      if (k == 5) chk("r031_pressed", {24'd0, pressed}, 32'h20);
      if (k == 6) chk("r031_led", {24'd0, led}, 32'h20);
      if (k >= 6) chk("r031_nostep", {31'd0, step}, 32'd0);
    end
    sw[5] = 1'b1;
    for (int k = 1; k <= 10; k++) begin
      tick();
      if (k == 9) chk("r031_led_hold", {24'd0, led}, 32'h20);
      if (k == 10) chk("r031_led10", {24'd0, led}, 32'h10);
    end

    // Two-cycle glitch must be rejected.
    sw[5] = 1'b0;
    ticks(2);
    sw[5] = 1'b1;
    ticks(8);
    chk("r032_pressed", {24'd0, pressed}, 32'h00);

    // Simultaneous presses: lowest index wins.
    sw[2] = 1'b0; sw[6] = 1'b0;
    ticks(6);
    chk("r033_led04", {24'd0, led}, 32'h04);
    sw[2] = 1'b1;
    ticks(6);
    chk("r033_led40", {24'd0, led}, 32'h40);
    sw[6] = 1'b1;
    ticks(12);

    // Wait for LED=80, then step toward MSB.
    found = 0;
    for (int k = 0; k < 60 && !found; k++) begin
      tick();
      if (led === 8'h80 && step === 1'b1) found = 1;
    end
    chk("wait_led80", {31'd0, found}, 32'd1);
    dir = 1'b1;
    ticks(4);
    chk("r034_wrap01", {24'd0, led}, 32'h01);

    // Pause mid-count, then resume.
    ticks(2);
    run = 1'b0;
    ticks(10);
    chk("r034_frozen", {24'd0, led}, 32'h01);
    run = 1'b1;
    ticks(12);

    // Reset during HOLD while the button stays down.
    dir = 1'b0;
    sw[3] = 1'b0;
    ticks(8);
    chk("r035_hold08", {24'd0, led}, 32'h08);
    do_reset();
    for (int k = 1; k <= D + 3; k++) begin
      tick();
      if (k == D + 3) chk("r035_led08", {24'd0, led}, 32'h08);
    end
    sw[3] = 1'b1;
    ticks(10);

    // Random activity.
    for (int c = 0; c < 3000; c++) begin
      if ($urandom_range(15) == 0) begin
        b = $urandom_range(N - 1);
        sw[b] = ~sw[b];
      end
      if ($urandom_range(31) == 0) sw = '1;
      if ($urandom_range(19) == 0) run = ~run;
      if ($urandom_range(9) == 0) dir = 1'($urandom_range(1));
      if ($urandom_range(599) == 0) do_reset();
      tick();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/button_led_sequencer.md
BUTTON_LED_SEQUENCER -- requirements
Module: button_led_sequencer

Interface
REQ-001 SHALL have parameter NUM_CH, default 8, meaning the number of button/LED channels (2..32).
REQ-002 SHALL have parameter STEP_CYC, default 16777216, meaning the Clk cycles per LED rotation step (>=2).
REQ-003 SHALL have parameter DEBOUNCE_CYC, default 1000000, meaning the consecutive stable cycles required to accept a button change (>=1).
REQ-004 SHALL have port Clk, input, 1 bit: the single clock; all state is on its rising edge.
REQ-005 SHALL have port Reset, input, 1 bit: asynchronous, active-high reset.
REQ-006 SHALL have port Switch, input, NUM_CH bits: raw asynchronous buttons, active-low (0 = pressed).
REQ-007 SHALL have port Run, input, 1 bit: 1 = rotation enabled, 0 = pause (synchronous level).
REQ-008 SHALL have port Dir, input, 1 bit: 0 = rotate toward LSB, 1 = rotate toward MSB.
REQ-009 SHALL have port LED, output, NUM_CH bits: LED pattern, always exactly one-hot.
REQ-010 SHALL have port Pressed, output, NUM_CH bits: debounced press levels (1 = pressed).
REQ-011 SHALL have port Step, output, 1 bit: one-cycle pulse on each cycle LED rotates.

Function
REQ-012 Each Switch bit SHALL pass a 2-flop synchronizer, then a per-channel debouncer.
REQ-013 The debouncer SHALL change Pressed[i] only after the synchronized input differs from it for DEBOUNCE_CYC consecutive cycles; any agreeing cycle clears its counter.
REQ-014 The latency from a Switch edge (held stable) to Pressed change SHALL be DEBOUNCE_CYC+2 cycles; LED SHALL update 1 cycle later.
REQ-015 The FSM SHALL have states RUN, HOLD and PAUSE.
REQ-016 From any state, when any Pressed bit is 1, the FSM SHALL enter/stay in HOLD and set LED to the one-hot of the lowest-indexed pressed channel.
REQ-017 In HOLD, stepping SHALL be suspended and the step counter held at 0.
REQ-018 On leaving HOLD (all Pressed = 0), the FSM SHALL go to RUN if Run=1, else PAUSE; LED keeps its last value.
REQ-019 In RUN, the step counter SHALL count 0..STEP_CYC-1; at terminal count it wraps to 0, LED rotates one position, and Step pulses.
REQ-020 Rotation SHALL wrap: Dir=0 moves bit0 to bit NUM_CH-1; Dir=1 moves bit NUM_CH-1 to bit0.
REQ-021 RUN->PAUSE on Run=0; PAUSE->RUN on Run=1; in PAUSE, the counter is frozen (not cleared) and LED is frozen.
REQ-022 When a press and a terminal count occur in the same cycle, the press SHALL win: no rotation, no Step pulse.
REQ-023 Dir SHALL be sampled only at the rotation cycle; Dir changes SHALL never corrupt the one-hot pattern.
REQ-024 The step counter width SHALL be $clog2(STEP_CYC); the debounce counter width SHALL be $clog2(DEBOUNCE_CYC+1).

Reset
REQ-025 Reset assertion SHALL immediately force LED to one-hot bit 0, Pressed to 0, Step to 0, all counters to 0, synchronizer flops to 1 (released), and the FSM to RUN.
REQ-026 Reset asserted mid-step or mid-debounce SHALL discard partial counts; after deassertion, operation SHALL restart from the reset state.

Structure
REQ-027 A shared package SHALL hold the FSM state enumeration (RUN, HOLD, PAUSE) and the default parameter constants.
REQ-028 A sub-module button_debounce (1 channel: synchronizer + debounce counter) SHALL be instantiated NUM_CH times via generate.
REQ-029 The FSM, step counter, priority encoder and rotator SHALL reside in button_led_sequencer.

Verification (NUM_CH=8, STEP_CYC=4, DEBOUNCE_CYC=3)
REQ-030 Reset release, Run=1, Dir=0, no press -> LED 01, 80, 40 at 4-cycle intervals, Step pulsing every 4th cycle.
REQ-031 Switch[5] low at cycle t, held -> Pressed=20 at t+5, LED=20 at t+6, no Step while held; release -> rotation to 10 four cycles after HOLD exit.
REQ-032 Switch[5] glitching low for 2 cycles, then high -> Pressed stays 00, LED unaffected.
REQ-033 Switch[2] and Switch[6] pressed simultaneously -> LED=04; release [2] only -> LED=40.
REQ-034 Dir=1 from LED=80 -> next step LED=01; Run=0 for 10 cycles mid-count -> LED frozen, then resumes with the remaining count.
REQ-035 Reset pulse during HOLD with Switch[3] held -> LED=01 immediately; LED=08 DEBOUNCE_CYC+3 cycles after release of reset.
